// File: rtl/ahb_pkg.sv
// Shared AHB encodings, controller state enum and burst beat-count decode.
package ahb_pkg;

    localparam int unsigned BEAT_W    = 5;
    localparam int unsigned MAX_BEATS = 16;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_ERR  = 3'd4,
        ST_DONE = 3'd5
    } ctrl_state_e;

    // INCR uses the requested length (0 means 1, clamped to 16); fixed bursts are implied by HBURST.
    function automatic logic [BEAT_W-1:0] total_beats(input logic [2:0] burst, input logic [4:0] len);
        logic [BEAT_W-1:0] beats;
        beats = BEAT_W'(1);
        unique case (hburst_e'(burst))
            BURST_SINGLE:              beats = BEAT_W'(1);
            BURST_INCR: begin
                if (len == 5'd0)
                    beats = BEAT_W'(1);
                else if (len > 5'(MAX_BEATS))
                    beats = BEAT_W'(MAX_BEATS);
                else
                    beats = BEAT_W'(len);
            end
            BURST_WRAP4,  BURST_INCR4:  beats = BEAT_W'(4);
            BURST_WRAP8,  BURST_INCR8:  beats = BEAT_W'(8);
            BURST_WRAP16, BURST_INCR16: beats = BEAT_W'(16);
            default:                   beats = BEAT_W'(1);
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_beat_counter.sv
// Latches the total beat count of a burst at accept and tracks the current beat.
module ahb_beat_counter
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] burst,
    input  logic [4:0] len,
    input  logic       advance,
    output logic       is_first,
    output logic       is_last
);

    logic [BEAT_W-1:0] count;
    logic [BEAT_W-1:0] total;

    // Count saturates at the burst length so a stray advance never wraps it.
    always_ff @(posedge HCLK) begin
        if (rst) begin
            count <= '0;
            total <= '0;
        end else if (load) begin
            count <= '0;
            total <= total_beats(burst, len);
        end else if (advance && (count != total)) begin
            count <= count + BEAT_W'(1);
        end
    end

    assign is_first = (count == '0);
    assign is_last  = (BEAT_W'(count + BEAT_W'(1)) == total);

endmodule

// File: rtl/ahb_master_ctrl.sv
// AHB master transfer sequencer: one request at a time, split ADDR/DATA phases per beat.
// Optional HREADY-low timeout in the data/error phase is built when AHBM_TIMEOUT_EN is defined.
module ahb_master_ctrl
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
`ifdef AHBM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              HCLK,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [2:0]        req_burst,
    input  logic              req_write,
    input  logic [4:0]        req_len,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [ADDR_W-1:0] dp_addr,
    output logic [2:0]        dp_size,
    output logic [2:0]        dp_burst,
    output logic              dp_start,
    output logic              dp_next_beat,
    output logic              dp_store_read,
    output logic              done,
    output logic              error,
    output logic              busy
);

    ctrl_state_e state;
    logic        accept;
    logic        beat_ok;
    logic        is_first;
    logic        is_last;
    logic        to_hit;

    assign accept  = req_valid && req_ready && (state == ST_IDLE);
    assign beat_ok = (state == ST_DATA) && HREADY && (HRESP == HRESP_OKAY);

    // Datapath strobes act on the edge that completes the beat, so they follow HREADY directly.
    assign dp_store_read = beat_ok && !HWRITE;
    assign dp_next_beat  = beat_ok && !is_last;

    ahb_beat_counter u_beats (
        .HCLK     (HCLK),
        .rst      (rst),
        .load     (accept),
        .burst    (req_burst),
        .len      (req_len),
        .advance  (dp_next_beat),
        .is_first (is_first),
        .is_last  (is_last)
    );

`ifdef AHBM_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_wait;

    assign to_hit  = !HREADY && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign to_wait = !HREADY && !to_hit &&
                     (((state == ST_DATA) && (HRESP == HRESP_OKAY)) || (state == ST_ERR));

    // Any cycle that is not a plain wait (HREADY high, state change, timeout) restarts the count.
    always_ff @(posedge HCLK) begin
        if (rst || !to_wait)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TO_W'(1);
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            HTRANS    <= HTRANS_IDLE;
            HWRITE    <= 1'b0;
            dp_addr   <= '0;
            dp_size   <= '0;
            dp_burst  <= '0;
            dp_start  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            dp_start <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dp_addr   <= req_addr;
                        dp_size   <= req_size;
                        dp_burst  <= req_burst;
                        HWRITE    <= req_write;
                        dp_start  <= 1'b1;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    HTRANS <= is_first ? HTRANS_NONSEQ : HTRANS_SEQ;
                    state  <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        HTRANS <= is_last ? HTRANS_IDLE : HTRANS_BUSY;
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (HRESP == HRESP_ERROR) begin
                        HTRANS <= HTRANS_IDLE;
                        state  <= ST_ERR;
                    end else if (HREADY) begin
                        if (is_last) begin
                            HTRANS <= HTRANS_IDLE;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            HTRANS <= HTRANS_SEQ;
                            state  <= ST_ADDR;
                        end
                    end else if (to_hit) begin
                        HTRANS <= HTRANS_IDLE;
                        done   <= 1'b1;
                        error  <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_ERR: begin
                    if (HREADY || to_hit) begin
                        done  <= 1'b1;
                        error <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    HTRANS    <= HTRANS_IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Directed bench for ahb_master_ctrl with a small datapath/slave model and a table of transfers.
module tb_ahb_master_ctrl;
    import ahb_pkg::*;

    logic       HCLK = 1'b0;
    logic       rst  = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_addr  = '0;
    logic [2:0] req_size  = '0;
    logic [2:0] req_burst = '0;
    logic       req_write = 1'b0;
    logic [4:0] req_len   = '0;
    logic       HREADY = 1'b1;
    logic       HRESP  = 1'b0;
    logic [1:0] HTRANS;
    logic       HWRITE;
    logic [7:0] dp_addr;
    logic [2:0] dp_size;
    logic [2:0] dp_burst;
    logic       dp_start, dp_next_beat, dp_store_read, done, error, busy;

    always #5 HCLK = ~HCLK;

    ahb_master_ctrl dut (
        .HCLK(HCLK), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size), .req_burst(req_burst),
        .req_write(req_write), .req_len(req_len), .HREADY(HREADY), .HRESP(HRESP),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .dp_addr(dp_addr), .dp_size(dp_size),
        .dp_burst(dp_burst), .dp_start(dp_start), .dp_next_beat(dp_next_beat),
        .dp_store_read(dp_store_read), .done(done), .error(error), .busy(busy)
    );

    // Datapath model: current-beat address with wrap, local word memory, pulse counters.
    logic [31:0] HRDATA = '0;
    logic [7:0]  cur = '0;
    logic [2:0]  m_size = '0, m_burst = '0;
    logic [31:0] mem [256];
    logic [7:0]  haddr_q [$];
    int nb_cnt = 0, sr_cnt = 0, dn_cnt = 0;
    int checks = 0, failures = 0;

    function automatic logic [7:0] next_addr(input logic [7:0] a, input logic [2:0] sz, input logic [2:0] bu);
        logic [7:0] step, mask;
        step = 8'(1) << sz;
        case (bu)
            3'd2:    mask = 8'(step << 2) - 8'd1;
            3'd4:    mask = 8'(step << 3) - 8'd1;
            3'd6:    mask = 8'(step << 4) - 8'd1;
            default: mask = 8'hFF;
        endcase
        return (a & ~mask) | (8'(a + step) & mask);
    endfunction

    always @(posedge HCLK) begin
        if (HTRANS[1] && HREADY) haddr_q.push_back(cur);
        if (dp_store_read) begin
            mem[cur] <= HRDATA;
            sr_cnt   <= sr_cnt + 1;
        end
        if (dp_start) begin
            cur <= dp_addr; m_size <= dp_size; m_burst <= dp_burst;
        end else if (dp_next_beat) begin
            cur    <= next_addr(cur, m_size, m_burst);
            nb_cnt <= nb_cnt + 1;
        end
        if (done) dn_cnt <= dn_cnt + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] addr; logic [2:0] size; logic [2:0] burst; logic wr; logic [4:0] len;
        int wait_beat; int wait_n; int err_beat; logic err_v;
        int e_cyc; int e_nb; int e_sr; logic e_err; int e_na; logic [7:0] e_last;
        int ht_n; logic [63:0] ht;
    } txn_t;

    // Issues one request and plays the slave; cyc is the cycle (accept = 0) in which done was seen.
    task automatic run_txn(input txn_t t, output int cyc, output logic err_o, output logic [63:0] htl);
        int beat, waited, est, wc;
        bit in_data;
        logic [1:0] ht_s;
        req_valid = 1'b1; req_addr = t.addr; req_size = t.size; req_burst = t.burst;
        req_write = t.wr; req_len = t.len; HREADY = 1'b1; HRESP = 1'b0;
        wc = 0;
        @(negedge HCLK);
        while (!req_ready && wc < 20) begin @(negedge HCLK); wc++; end
        chk("accept_ready", 64'(req_ready), 64'(1));
        @(posedge HCLK); #1;
        req_valid = 1'b0;
        cyc = -1; err_o = 1'b0; htl = '0;
        beat = 0; waited = 0; est = t.err_v ? 1 : 0; in_data = 1'b0;
        for (int c = 1; c <= 100 && cyc < 0; c++) begin
            HRESP = 1'b0; HREADY = 1'b1;
            if (in_data) begin
                if (beat == t.err_beat) begin
                    HRESP = 1'b1; HREADY = (est == 1);
                end else if (beat == t.wait_beat && waited < t.wait_n) begin
                    HREADY = 1'b0;
                end
            end
            HRDATA = 32'hDEADBEEF + 32'(beat);
            @(negedge HCLK);
            ht_s = HTRANS;
            if (c <= 32) htl[2*(c-1) +: 2] = ht_s;
            if (done) begin cyc = c; err_o = error; end
            @(posedge HCLK); #1;
            if (in_data) begin
                if (beat == t.err_beat) begin
                    if (est == 0) est = 1; else in_data = 1'b0;
                end else if (HREADY) begin
                    in_data = 1'b0; beat++;
                end else begin
                    waited++;
                end
            end else if (ht_s[1] && HREADY) begin
                in_data = 1'b1;
            end
        end
        HREADY = 1'b1; HRESP = 1'b0;
    endtask

    txn_t tv [9];
    txn_t s;
    int cyc, nb0, sr0, dn0, hq0, na, wc;
    logic e;
    logic [63:0] htl, exp_ht;
    logic [7:0] last_a;

    initial begin
        tv[0] = '{8'h10, 3'd2, BURST_SINGLE, 1'b0, 5'd0,  -1, 0, -1, 1'b0,  4,  0, 1, 1'b0,  1, 8'h10,  3, 64'h8};
        tv[1] = '{8'h20, 3'd2, BURST_INCR4,  1'b1, 5'd0,   1, 2, -1, 1'b0, 12,  3, 0, 1'b0,  4, 8'h2C, 11, 64'hDD5D8};
        tv[2] = '{8'h38, 3'd2, BURST_WRAP4,  1'b0, 5'd0,  -1, 0, -1, 1'b0, 10,  3, 4, 1'b0,  4, 8'h34,  0, 64'h0};
        tv[3] = '{8'h40, 3'd2, BURST_INCR8,  1'b0, 5'd0,  -1, 0,  2, 1'b0,  9,  2, 2, 1'b1,  3, 8'h48,  6, 64'hDD8};
        tv[4] = '{8'h05, 3'd0, BURST_INCR,   1'b0, 5'd0,  -1, 0, -1, 1'b0,  4,  0, 1, 1'b0,  1, 8'h05,  0, 64'h0};
        tv[5] = '{8'h80, 3'd1, BURST_INCR,   1'b1, 5'd3,  -1, 0, -1, 1'b0,  8,  2, 0, 1'b0,  3, 8'h84,  0, 64'h0};
        tv[6] = '{8'hFC, 3'd0, BURST_WRAP8,  1'b0, 5'd0,  -1, 0, -1, 1'b0, 18,  7, 8, 1'b0,  8, 8'hFB,  0, 64'h0};
        tv[7] = '{8'h00, 3'd0, BURST_INCR16, 1'b1, 5'd0,  -1, 0, -1, 1'b0, 34, 15, 0, 1'b0, 16, 8'h0F,  0, 64'h0};
        tv[8] = '{8'h50, 3'd2, BURST_SINGLE, 1'b0, 5'd0,  -1, 0,  0, 1'b1,  5,  0, 0, 1'b1,  1, 8'h50,  0, 64'h0};

        repeat (3) @(posedge HCLK);
        #1 rst = 1'b0;
        @(negedge HCLK);
        chk("rst_htrans", 64'(HTRANS), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(1));
        chk("rst_done_err", 64'({done, error, dp_start, HWRITE}), 64'(0));
        chk("rst_dp", 64'({dp_addr, dp_size, dp_burst}), 64'(0));
        @(posedge HCLK); #1;

        for (int i = 0; i < 9; i++) begin
            nb0 = nb_cnt; sr0 = sr_cnt; dn0 = dn_cnt; hq0 = haddr_q.size();
            run_txn(tv[i], cyc, e, htl);
            na = haddr_q.size() - hq0;
            last_a = (haddr_q.size() > 0) ? haddr_q[haddr_q.size()-1] : 8'h00;
            chk($sformatf("t%0d_done_cycle", i), 64'(cyc), 64'(tv[i].e_cyc));
            chk($sformatf("t%0d_error", i), 64'(e), 64'(tv[i].e_err));
            chk($sformatf("t%0d_done_pulses", i), 64'(dn_cnt - dn0), 64'(1));
            chk($sformatf("t%0d_next_beat", i), 64'(nb_cnt - nb0), 64'(tv[i].e_nb));
            chk($sformatf("t%0d_store_read", i), 64'(sr_cnt - sr0), 64'(tv[i].e_sr));
            chk($sformatf("t%0d_addr_beats", i), 64'(na), 64'(tv[i].e_na));
            chk($sformatf("t%0d_last_haddr", i), 64'(last_a), 64'(tv[i].e_last));
            chk($sformatf("t%0d_dp_hold", i), 64'({dp_addr, dp_size, dp_burst, HWRITE}),
                64'({tv[i].addr, tv[i].size, tv[i].burst, tv[i].wr}));
            chk($sformatf("t%0d_idle_after", i), 64'({busy, req_ready}), 64'(2'b01));
            exp_ht = tv[i].ht;
            for (int j = 0; j < tv[i].ht_n; j++)
                chk($sformatf("t%0d_htrans_%0d", i, j), 64'(htl[2*j +: 2]), 64'(exp_ht[2*j +: 2]));
            if (i == 3) chk("t3_htrans_err_phase", 64'(htl[15:14]), 64'(0));
        end
        chk("mem_single", 64'(mem[8'h10]), 64'(32'hDEADBEEF));
        chk("mem_wrap_38", 64'(mem[8'h38]), 64'(32'hDEADBEEF));
        chk("mem_wrap_3c", 64'(mem[8'h3C]), 64'(32'hDEADBEF0));
        chk("mem_wrap_30", 64'(mem[8'h30]), 64'(32'hDEADBEF1));
        chk("mem_wrap_34", 64'(mem[8'h34]), 64'(32'hDEADBEF2));

        // Reset while beat 3 of an INCR16 read is in flight.
        nb0 = nb_cnt; dn0 = dn_cnt;
        req_valid = 1'b1; req_addr = 8'hA0; req_size = 3'd0; req_burst = BURST_INCR16;
        req_write = 1'b0; req_len = 5'd0; HREADY = 1'b1; HRESP = 1'b0;
        @(posedge HCLK); #1;
        req_valid = 1'b0;
        wc = 0;
        while ((nb_cnt - nb0) < 3 && wc < 40) begin @(posedge HCLK); #1; wc++; end
        chk("abort_reached_beat3", 64'(nb_cnt - nb0), 64'(3));
        rst = 1'b1;
        @(posedge HCLK); #1;
        rst = 1'b0;
        @(negedge HCLK);
        chk("abort_htrans", 64'(HTRANS), 64'(0));
        chk("abort_busy_ready", 64'({busy, req_ready}), 64'(2'b01));
        chk("abort_dp_addr", 64'(dp_addr), 64'(0));
        repeat (3) @(posedge HCLK);
        #1;
        chk("abort_no_done", 64'(dn_cnt - dn0), 64'(0));
        s = '{8'h60, 3'd2, BURST_SINGLE, 1'b0, 5'd0, -1, 0, -1, 1'b0, 4, 0, 1, 1'b0, 1, 8'h60, 0, 64'h0};
        sr0 = sr_cnt;
        run_txn(s, cyc, e, htl);
        chk("post_abort_cycle", 64'(cyc), 64'(4));
        chk("post_abort_error", 64'(e), 64'(0));
        chk("post_abort_store", 64'(sr_cnt - sr0), 64'(1));
        chk("post_abort_mem", 64'(mem[8'h60]), 64'(32'hDEADBEEF));

        // Data phase stuck with HREADY low.
        sr0 = sr_cnt; dn0 = dn_cnt;
        req_valid = 1'b1; req_addr = 8'h90; req_size = 3'd2; req_burst = BURST_INCR4;
        req_write = 1'b0; req_len = 5'd0; HREADY = 1'b1; HRESP = 1'b0;
        @(posedge HCLK); #1;
        req_valid = 1'b0;
        wc = 0;
        @(negedge HCLK);
        while (HTRANS != 2'b10 && wc < 10) begin @(negedge HCLK); wc++; end
        chk("stall_addr_phase", 64'(HTRANS), 64'(2'b10));
        @(posedge HCLK); #1;
        HREADY = 1'b0;
        cyc = -1; e = 1'b0;
        for (int k = 0; k < 200 && cyc < 0; k++) begin
            @(negedge HCLK);
            if (done) begin cyc = k; e = error; end
            @(posedge HCLK); #1;
        end
`ifdef AHBM_TIMEOUT_EN
        chk("timeout_cycle", 64'(cyc), 64'(64));
        chk("timeout_error", 64'(e), 64'(1));
`else
        chk("no_timeout_done", 64'(cyc), 64'(-1));
        chk("no_timeout_busy", 64'({busy, HTRANS}), 64'({1'b1, 2'b01}));
`endif
        chk("stall_no_store", 64'(sr_cnt - sr0), 64'(0));
        rst = 1'b1; HREADY = 1'b1;
        @(posedge HCLK); #1;
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
